hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32I core. It tracks destination registers of instructions in EX, MEM and WB and generates stall, flush and freeze controls for the IF/ID and ID/EX registers. It also produces registered forwarding selects that stay aligned with the instruction entering EX. It sits beside the decode stage and is the only source of pipeline sequencing.

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32I core.
//
// Tracks the destination of the instructions in EX, MEM and WB and derives the
// stall/flush/freeze sequencing for IF/ID and ID/EX. It also produces the EX operand
// forwarding selects, which are registered alongside the instruction entering EX.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_id_*                         decoded fields of the instruction in ID
//   i_ex_redirect                  taken branch / JAL / JALR resolved in EX
//   i_mem_req, i_mem_ready         data-memory handshake of the MEM stage
//   o_stall_if, o_stall_id         hold PC / hold IF/ID
//   o_flush_if, o_flush_id         bubble into IF/ID / bubble into ID/EX
//   o_freeze                       hold every pipeline register
//   o_fwd_a, o_fwd_b               registered EX operand select (00 ID/EX, 10 MEM, 01 WB)
//   o_byp_a, o_byp_b               ID captures WB write data for rs1/rs2
//   o_stall_cnt, o_flush_cnt       performance counters, only with HAZARD_PERF_EN
//
// Build option: define HAZARD_PERF_EN to add the stall and flush counters.
module hazard_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_id_valid,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic            i_id_rs1_used,
  input  logic            i_id_rs2_used,
  input  logic [4:0]      i_id_rd,
  input  logic            i_id_rf_wr,
  input  logic            i_id_is_load,
  input  logic            i_ex_redirect,
  input  logic            i_mem_req,
  input  logic            i_mem_ready,
  output logic            o_stall_if,
  output logic            o_stall_id,
  output logic            o_flush_if,
  output logic            o_flush_id,
  output logic            o_freeze,
  output logic [1:0]      o_fwd_a,
  output logic [1:0]      o_fwd_b,
  output logic            o_byp_a,
`ifdef HAZARD_PERF_EN
  output logic            o_byp_b,
  output logic [XLEN-1:0] o_stall_cnt,
  output logic [XLEN-1:0] o_flush_cnt
`else
  output logic            o_byp_b
`endif
);

  if (XLEN == 0) begin : g_bad_xlen
    $error("hazard_ctrl: XLEN must be nonzero");
  end

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_wr;
    logic       is_load;
  } trk_t;

  typedef enum logic [0:0] {StRun, StFreeze} state_e;

  localparam trk_t TrkBubble = '{valid: 1'b0, rd: 5'd0, rf_wr: 1'b0, is_load: 1'b0};

  state_e     state_q;
  trk_t       ex_q, mem_q, wb_q;
  trk_t       ex_d;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic       freeze, load_use;

  // A tracker supplies a source only if it really writes a nonzero register.
  function automatic logic hit(input trk_t t, input logic [4:0] rs, input logic used);
    return used & t.valid & t.rf_wr & (t.rd != 5'd0) & (t.rd == rs);
  endfunction

  // A load in EX has no data yet, so only non-load EX results are forwarded.
  function automatic logic [1:0] fwd_sel(input trk_t ex, input trk_t mem,
                                         input logic [4:0] rs, input logic used);
    if (hit(ex, rs, used) && !ex.is_load) return 2'b10;
    else if (hit(mem, rs, used))          return 2'b01;
    else                                  return 2'b00;
  endfunction

  assign freeze   = i_mem_req & ~i_mem_ready;
  assign load_use = i_id_valid & ex_q.is_load &
                    (hit(ex_q, i_id_rs1, i_id_rs1_used) | hit(ex_q, i_id_rs2, i_id_rs2_used));

  // Freeze masks everything; a redirect discards the wrong-path ID instruction,
  // so it wins over a load-use stall.
  always_comb begin
    o_stall_if = 1'b0;
    o_stall_id = 1'b0;
    o_flush_if = 1'b0;
    o_flush_id = 1'b0;
    if (!freeze) begin
      if (i_ex_redirect) begin
        o_flush_if = 1'b1;
        o_flush_id = 1'b1;
      end else if (load_use) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_flush_id = 1'b1;
      end
    end
  end

  assign o_freeze = freeze;
  assign o_byp_a  = hit(wb_q, i_id_rs1, i_id_rs1_used);
  assign o_byp_b  = hit(wb_q, i_id_rs2, i_id_rs2_used);

  always_comb begin
    ex_d    = TrkBubble;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (i_id_valid && !o_flush_id) begin
      ex_d    = '{valid: 1'b1, rd: i_id_rd, rf_wr: i_id_rf_wr, is_load: i_id_is_load};
      fwd_a_d = fwd_sel(ex_q, mem_q, i_id_rs1, i_id_rs1_used);
      fwd_b_d = fwd_sel(ex_q, mem_q, i_id_rs2, i_id_rs2_used);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      ex_q    <= TrkBubble;
      mem_q   <= TrkBubble;
      wb_q    <= TrkBubble;
      o_fwd_a <= 2'b00;
      o_fwd_b <= 2'b00;
    end else begin
      unique case (state_q)
        StRun:    if (freeze)  state_q <= StFreeze;
        StFreeze: if (!freeze) state_q <= StRun;
        default:               state_q <= StRun;
      endcase
      if (!freeze) begin
        wb_q    <= mem_q;
        mem_q   <= ex_q;
        ex_q    <= ex_d;
        o_fwd_a <= fwd_a_d;
        o_fwd_b <= fwd_b_d;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (freeze || o_stall_id) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (o_flush_if)           o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
